ysyx_25020047_exec_ctrl: RTL and testbench
==========================================

Name: ysyx_25020047_exec_ctrl

Overview:
Multi-cycle sequencer for the single-issue core. Steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with the instruction-fetch and load/store ports. Generates the commit strobes (register-file write enable, PC update) that qualify the writeback unit's combinational wdata/dnpc outputs. Detects illegal instruction types and bus timeouts, and counts cycles and retired instructions.

Parameters:
TIMEOUT, 255, max cycles waiting for ifu_rvalid or lsu_rvalid before trapping (1..65535)
CNT_W, 32, width of cycle/instret counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ifu_req  out  1  fetch request, held until ifu_rvalid
ifu_rvalid  in  1  fetch response valid; instruction available this cycle
ir_en  out  1  latch instruction register (equals ifu_req & ifu_rvalid)
inst_type  in  32  one-hot decoded type from IDU (stable from ID until next IF)
lsu_req  out  1  memory request, held until lsu_rvalid
lsu_we  out  1  1 = store, 0 = load; valid while lsu_req
lsu_rvalid  in  1  memory response valid
reg_wen  out  1  one-cycle register-file write strobe
pc_wen  out  1  one-cycle PC update strobe (PC <= dnpc)
halt  out  1  core stopped in TRAP
trap_cause  out  2  0 none, 1 illegal type, 2 fetch timeout, 3 memory timeout
state  out  3  current FSM state (debug)
cycle_cnt  out  CNT_W  cycles since reset
instret_cnt  out  CNT_W  retired instructions

Behaviour:
- Reset (async, immediate): state=IF; ifu_req=0; lsu_req=0; lsu_we=0; ir_en=0; reg_wen=0; pc_wen=0; halt=0; trap_cause=0; counters=0; watchdog=0. Reset mid-transaction abandons the outstanding request; no strobe is issued.
- State encoding: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
- IF: ifu_req=1 (registered; asserted from the first cycle after reset release). On ifu_rvalid: ir_en=1 that cycle, ifu_req drops next cycle, go to ID.
- ID: one cycle. inst_type zero or not one-hot -> TRAP, cause 1. Otherwise -> EX.
- EX: one cycle. Load (0x20 lw, 0x40 lbu) or store (0x80 sw, 0x100 sb) -> MEM. Otherwise -> WB.
- MEM: lsu_req=1; lsu_we=1 for store types. On lsu_rvalid -> WB; lsu_req drops next cycle.
- WB: one cycle. pc_wen=1 always. reg_wen=1 unless type is store, beq (0x4000) or bne (0x8000). instret_cnt += 1. Next -> IF.
- Latency: ALU op with zero-wait memory = IF(1)+ID+EX+WB = 4 cycles/instr; load/store = 5.
- ifu_rvalid/lsu_rvalid outside the matching wait state: ignored.
- Watchdog:
  - Counts cycles in IF and in MEM; cleared on every state change.
  - Reaching TIMEOUT without a response -> TRAP, cause 2 (IF) or 3 (MEM).
  - A response arriving in the same cycle the count reaches TIMEOUT wins; no trap.
- TRAP:
  - Absorbing until reset: halt=1; all requests and strobes 0.
  - trap_cause holds.
  - cycle_cnt stops.
- cycle_cnt increments every non-TRAP cycle; both counters wrap modulo 2^CNT_W silently.
- All outputs registered except ir_en, which is combinational on ifu_rvalid.

Test Plan:
- Reset, then addi (0x1) with ifu_rvalid on the 1st request cycle -> state sequence 0,1,2,4,0. reg_wen=1 and pc_wen=1 in cycle 4 only. instret_cnt=1, cycle_cnt=4 at the next IF.
- lw (0x20) with lsu_rvalid after 3 wait cycles -> lsu_req high 4 cycles, lsu_we=0, then WB with reg_wen=1. sw (0x80) -> lsu_we=1, reg_wen=0, pc_wen=1.
- beq (0x4000) -> WB with pc_wen=1, reg_wen=0. inst_type=0x3 or 0x0 in ID -> state=7, halt=1, trap_cause=1, no strobes afterwards.
- TIMEOUT=4, ifu_rvalid never asserted -> TRAP after 4 IF cycles, cause 2. ifu_rvalid on the 4th cycle -> no trap, goes to ID. Same check in MEM -> cause 3.
- Assert rst during MEM with lsu_req=1 -> all outputs 0 immediately (asynchronously). After release: state=IF, ifu_req=1 the next cycle, counters 0.
- CNT_W=4, run 16 addi -> instret_cnt wraps to 0 without disturbing sequencing. Spurious lsu_rvalid in IF/ID/EX has no effect.

Source files
------------

// File: rtl/ysyx_25020047_exec_ctrl_if.sv
`default_nettype none
// Handshake bundle between the execution sequencer and the fetch, decode,
// load/store and writeback units.
interface ysyx_25020047_exec_ctrl_if;
  logic        ifu_req;
  logic        ifu_rvalid;
  logic        ir_en;
  logic [31:0] inst_type;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_rvalid;
  logic        reg_wen;
  logic        pc_wen;

  modport master (
    output ifu_req,
    output ir_en,
    output lsu_req,
    output lsu_we,
    output reg_wen,
    output pc_wen,
    input  ifu_rvalid,
    input  inst_type,
    input  lsu_rvalid
  );

  modport slave (
    input  ifu_req,
    input  ir_en,
    input  lsu_req,
    input  lsu_we,
    input  reg_wen,
    input  pc_wen,
    output ifu_rvalid,
    output inst_type,
    output lsu_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_25020047_exec_ctrl.sv
`default_nettype none
// Multi-cycle IF/ID/EX/MEM/WB sequencer: bus handshakes, commit strobes,
// illegal-type and bus-timeout traps, cycle and retired-instruction counters.
module ysyx_25020047_exec_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  ysyx_25020047_exec_ctrl_if.master bus,
  output logic                      halt,
  output logic [1:0]                trap_cause,
  output logic [2:0]                state,
  output logic [CNT_W-1:0]          cycle_cnt,
  output logic [CNT_W-1:0]          instret_cnt
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd7
  } state_t;

  localparam logic [31:0]      T_LW    = 32'h0000_0020;
  localparam logic [31:0]      T_LBU   = 32'h0000_0040;
  localparam logic [31:0]      T_SW    = 32'h0000_0080;
  localparam logic [31:0]      T_SB    = 32'h0000_0100;
  localparam logic [31:0]      T_BEQ   = 32'h0000_4000;
  localparam logic [31:0]      T_BNE   = 32'h0000_8000;
  localparam logic [15:0]      WD_LAST = 16'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IFU_TO  = 2'd2;
  localparam logic [1:0] CAUSE_LSU_TO  = 2'd3;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_nxt;
  logic             r_ifu_req;
  logic             r_lsu_req;
  logic             r_lsu_we;
  logic             r_reg_wen;
  logic             r_pc_wen;
  logic             r_halt;
  logic [15:0]      r_wdog;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_instret;

  logic w_one_hot;
  logic w_is_mem;
  logic w_is_store;
  logic w_no_rd;
  logic w_ifu_fire;
  logic w_lsu_fire;
  logic w_wd_expired;
  logic w_wd_count;
  logic w_cycle_en;

  assign w_one_hot    = (bus.inst_type != 32'd0) &&
                        ((bus.inst_type & (bus.inst_type - 32'd1)) == 32'd0);
  assign w_is_store   = |(bus.inst_type & (T_SW | T_SB));
  assign w_is_mem     = w_is_store | (|(bus.inst_type & (T_LW | T_LBU)));
  assign w_no_rd      = w_is_store | (|(bus.inst_type & (T_BEQ | T_BNE)));
  assign w_ifu_fire   = r_ifu_req & bus.ifu_rvalid;
  assign w_lsu_fire   = r_lsu_req & bus.lsu_rvalid;
  assign w_wd_expired = (r_wdog == WD_LAST);
  assign w_wd_count   = ((r_state == S_IF) && r_ifu_req) || (r_state == S_MEM);
  // The start-up IF cycle right after reset, before the first request, is not counted.
  assign w_cycle_en   = (r_state != S_TRAP) && !((r_state == S_IF) && !r_ifu_req);

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      S_IF: begin
        if (w_ifu_fire) begin
          w_state_nxt = S_ID;
        end else if (r_ifu_req && w_wd_expired) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_IFU_TO;
        end
      end
      S_ID: begin
        if (w_one_hot) begin
          w_state_nxt = S_EX;
        end else begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_ILLEGAL;
        end
      end
      S_EX: begin
        w_state_nxt = w_is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        // A response in the expiring cycle takes priority over the timeout.
        if (w_lsu_fire) begin
          w_state_nxt = S_WB;
        end else if (w_wd_expired) begin
          w_state_nxt = S_TRAP;
          w_cause_nxt = CAUSE_LSU_TO;
        end
      end
      S_WB:    w_state_nxt = S_IF;
      S_TRAP:  w_state_nxt = S_TRAP;
      default: w_state_nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IF;
      r_cause   <= 2'd0;
      r_ifu_req <= 1'b0;
      r_lsu_req <= 1'b0;
      r_lsu_we  <= 1'b0;
      r_reg_wen <= 1'b0;
      r_pc_wen  <= 1'b0;
      r_halt    <= 1'b0;
      r_wdog    <= 16'd0;
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cause   <= w_cause_nxt;
      r_ifu_req <= (w_state_nxt == S_IF);
      r_lsu_req <= (w_state_nxt == S_MEM);
      r_lsu_we  <= (w_state_nxt == S_MEM) && w_is_store;
      r_reg_wen <= (w_state_nxt == S_WB) && !w_no_rd;
      r_pc_wen  <= (w_state_nxt == S_WB);
      r_halt    <= (w_state_nxt == S_TRAP);

      if (w_state_nxt != r_state) begin
        r_wdog <= 16'd0;
      end else if (w_wd_count) begin
        r_wdog <= r_wdog + 16'd1;
      end

      if (w_cycle_en) begin
        r_cycle <= r_cycle + CNT_ONE;
      end
      if (r_state == S_WB) begin
        r_instret <= r_instret + CNT_ONE;
      end
    end
  end

  assign bus.ifu_req  = r_ifu_req;
  assign bus.ir_en    = w_ifu_fire;
  assign bus.lsu_req  = r_lsu_req;
  assign bus.lsu_we   = r_lsu_we;
  assign bus.reg_wen  = r_reg_wen;
  assign bus.pc_wen   = r_pc_wen;
  assign halt         = r_halt;
  assign trap_cause   = r_cause;
  assign state        = r_state;
  assign cycle_cnt    = r_cycle;
  assign instret_cnt  = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25020047_exec_ctrl.sv
`default_nettype none
// Directed bench for the execution sequencer, built with a short watchdog
// and narrow counters so timeouts and counter wrap are reachable quickly.
module tb_ysyx_25020047_exec_ctrl;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             halt;
  logic [1:0]       trap_cause;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  int               n_checks = 0;
  int               n_fail   = 0;

  ysyx_25020047_exec_ctrl_if bus();

  ysyx_25020047_exec_ctrl #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halt        (halt),
    .trap_cause  (trap_cause),
    .state       (state),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic ifr,
                            input logic lr, input logic lw, input logic rw, input logic pw);
    check({tag, ".state"},   32'(state),       32'(st));
    check({tag, ".ifu_req"}, 32'(bus.ifu_req), 32'(ifr));
    check({tag, ".lsu_req"}, 32'(bus.lsu_req), 32'(lr));
    check({tag, ".lsu_we"},  32'(bus.lsu_we),  32'(lw));
    check({tag, ".reg_wen"}, 32'(bus.reg_wen), 32'(rw));
    check({tag, ".pc_wen"},  32'(bus.pc_wen),  32'(pw));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch handshake: the instruction arrives on the current request cycle.
  task automatic fetch(input logic [31:0] t);
    bus.inst_type  = t;
    bus.ifu_rvalid = 1'b1;
    tick();
    bus.ifu_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not finish, observed hang expected finish");
    $fatal(1);
  end

  initial begin
    bus.ifu_rvalid = 1'b0;
    bus.lsu_rvalid = 1'b0;
    bus.inst_type  = 32'd0;
    rst            = 1'b1;
    tick();
    tick();

    expect_cyc("reset", 3'd0, 0, 0, 0, 0, 0);
    check("reset.halt",    32'(halt),        32'd0);
    check("reset.cause",   32'(trap_cause),  32'd0);
    check("reset.cycle",   32'(cycle_cnt),   32'd0);
    check("reset.instret", 32'(instret_cnt), 32'd0);
    check("reset.ir_en",   32'(bus.ir_en),   32'd0);

    rst = 1'b0;
    tick();
    expect_cyc("start", 3'd0, 1, 0, 0, 0, 0);
    check("start.cycle", 32'(cycle_cnt), 32'd0);

    // addi on the first request cycle
    bus.inst_type  = 32'h1;
    bus.ifu_rvalid = 1'b1;
    #1;
    check("addi.ir_en", 32'(bus.ir_en), 32'd1);
    tick();
    bus.ifu_rvalid = 1'b0;
    expect_cyc("addi_id", 3'd1, 0, 0, 0, 0, 0);
    check("addi_id.ir_en", 32'(bus.ir_en), 32'd0);
    tick();
    expect_cyc("addi_ex", 3'd2, 0, 0, 0, 0, 0);
    tick();
    expect_cyc("addi_wb", 3'd4, 0, 0, 0, 1, 1);
    tick();
    expect_cyc("addi_if", 3'd0, 1, 0, 0, 0, 0);
    check("addi_if.instret", 32'(instret_cnt), 32'd1);
    check("addi_if.cycle",   32'(cycle_cnt),   32'd4);

    // lw, response on the 4th MEM cycle (also the watchdog boundary)
    fetch(32'h20);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      expect_cyc($sformatf("lw_mem%0d", i), 3'd3, 0, 1, 0, 0, 0);
      if (i == 3) bus.lsu_rvalid = 1'b1;
      tick();
    end
    bus.lsu_rvalid = 1'b0;
    expect_cyc("lw_wb", 3'd4, 0, 0, 0, 1, 1);
    tick();

    // sw, zero-wait memory
    fetch(32'h80);
    tick();
    tick();
    expect_cyc("sw_mem", 3'd3, 0, 1, 1, 0, 0);
    bus.lsu_rvalid = 1'b1;
    tick();
    bus.lsu_rvalid = 1'b0;
    expect_cyc("sw_wb", 3'd4, 0, 0, 0, 0, 1);
    tick();

    // beq: PC update only
    fetch(32'h4000);
    tick();
    expect_cyc("beq_ex", 3'd2, 0, 0, 0, 0, 0);
    tick();
    expect_cyc("beq_wb", 3'd4, 0, 0, 0, 0, 1);
    tick();
    expect_cyc("beq_if", 3'd0, 1, 0, 0, 0, 0);
    check("beq_if.instret", 32'(instret_cnt), 32'd4);
    check("beq_if.cycle",   32'(cycle_cnt),   32'd5);

    // illegal (non one-hot) type traps from ID
    fetch(32'h3);
    tick();
    expect_cyc("ill_trap", 3'd7, 0, 0, 0, 0, 0);
    check("ill_trap.halt",  32'(halt),       32'd1);
    check("ill_trap.cause", 32'(trap_cause), 32'd1);
    check("ill_trap.cycle", 32'(cycle_cnt),  32'd7);
    bus.ifu_rvalid = 1'b1;
    bus.lsu_rvalid = 1'b1;
    repeat (3) tick();
    expect_cyc("trap_hold", 3'd7, 0, 0, 0, 0, 0);
    check("trap_hold.ir_en", 32'(bus.ir_en),  32'd0);
    check("trap_hold.cycle", 32'(cycle_cnt),  32'd7);
    check("trap_hold.cause", 32'(trap_cause), 32'd1);
    check("trap_hold.halt",  32'(halt),       32'd1);
    bus.ifu_rvalid = 1'b0;
    bus.lsu_rvalid = 1'b0;

    // fetch response on the last watchdog cycle wins; then zero type traps
    do_reset();
    check("rst1.halt", 32'(halt), 32'd0);
    repeat (3) tick();
    expect_cyc("if_bnd_wait", 3'd0, 1, 0, 0, 0, 0);
    bus.inst_type  = 32'h0;
    bus.ifu_rvalid = 1'b1;
    #1;
    check("if_bnd.ir_en", 32'(bus.ir_en), 32'd1);
    tick();
    bus.ifu_rvalid = 1'b0;
    expect_cyc("if_bnd_id", 3'd1, 0, 0, 0, 0, 0);
    tick();
    check("zero_type.state", 32'(state),      32'd7);
    check("zero_type.cause", 32'(trap_cause), 32'd1);

    // fetch timeout
    do_reset();
    repeat (3) tick();
    check("ifto_pre.state", 32'(state), 32'd0);
    tick();
    expect_cyc("ifto", 3'd7, 0, 0, 0, 0, 0);
    check("ifto.cause", 32'(trap_cause), 32'd2);
    check("ifto.halt",  32'(halt),       32'd1);
    check("ifto.cycle", 32'(cycle_cnt),  32'd4);

    // memory timeout (lbu)
    do_reset();
    fetch(32'h40);
    tick();
    tick();
    repeat (3) tick();
    expect_cyc("memto_pre", 3'd3, 0, 1, 0, 0, 0);
    tick();
    expect_cyc("memto", 3'd7, 0, 0, 0, 0, 0);
    check("memto.cause", 32'(trap_cause), 32'd3);
    check("memto.halt",  32'(halt),       32'd1);
    check("memto.cycle", 32'(cycle_cnt),  32'd7);

    // asynchronous reset while a store is outstanding
    do_reset();
    fetch(32'h100);
    tick();
    tick();
    expect_cyc("sb_mem", 3'd3, 0, 1, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    expect_cyc("async_rst", 3'd0, 0, 0, 0, 0, 0);
    check("async_rst.halt",    32'(halt),        32'd0);
    check("async_rst.cycle",   32'(cycle_cnt),   32'd0);
    check("async_rst.instret", 32'(instret_cnt), 32'd0);
    tick();
    rst = 1'b0;
    check("rel.ifu_req", 32'(bus.ifu_req), 32'd0);
    tick();
    expect_cyc("rel_next", 3'd0, 1, 0, 0, 0, 0);
    check("rel_next.cycle", 32'(cycle_cnt), 32'd0);

    // 16 addi with spurious lsu_rvalid: instret and cycle_cnt wrap to 0
    bus.lsu_rvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      fetch(32'h1);
      expect_cyc($sformatf("wrap_id%0d", i), 3'd1, 0, 0, 0, 0, 0);
      tick();
      tick();
      expect_cyc($sformatf("wrap_wb%0d", i), 3'd4, 0, 0, 0, 1, 1);
      tick();
    end
    bus.lsu_rvalid = 1'b0;
    expect_cyc("wrap_if", 3'd0, 1, 0, 0, 0, 0);
    check("wrap.instret", 32'(instret_cnt), 32'd0);
    check("wrap.cycle",   32'(cycle_cnt),   32'd0);
    fetch(32'h1);
    tick();
    tick();
    tick();
    check("wrap_next.instret", 32'(instret_cnt), 32'd1);
    check("wrap_next.state",   32'(state),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
